// File: rtl/preimage_search_pkg.sv
// Shared types for the preimage search sweeper: FSM state encoding and the settle counter width.
package preimage_search_pkg;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_e;
endpackage

// File: rtl/preimage_search_if.sv
// Control, CUT and match-stream bundle for preimage_search; slave = the search engine side.
interface preimage_search_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 8
);
  logic             start;
  logic [N_OUT-1:0] target;
  logic [N_OUT-1:0] care;
  logic [N_IN-1:0]  cut_x;
  logic [N_OUT-1:0] cut_f;
  logic             m_valid;
  logic             m_ready;
  logic [N_IN-1:0]  m_x;
  logic             busy;
  logic             done;
  logic [N_IN:0]    match_count;

  modport slave (
    input  start, target, care, cut_f, m_ready,
    output cut_x, m_valid, m_x, busy, done, match_count
  );

  modport master (
    output start, target, care, cut_f, m_ready,
    input  cut_x, m_valid, m_x, busy, done, match_count
  );
endinterface

// File: rtl/preimage_search.sv
// Sweeps every CUT input assignment, compares masked outputs against a target and streams
// out each matching assignment in ascending order, then pulses done with the match count.
module preimage_search
  import preimage_search_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  preimage_search_if.slave  bus
);
  localparam logic [N_IN-1:0]     LAST      = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] WAIT_LAST = SETTLE_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [SETTLE_W-1:0] wait_q, wait_d;
  logic [N_IN:0]       count_q, count_d;
  logic [N_IN:0]       mc_q, mc_d;
  logic [N_OUT-1:0]    target_q, target_d;
  logic [N_OUT-1:0]    care_q, care_d;
  logic [N_IN-1:0]     m_x_q, m_x_d;
  logic                m_valid_q, m_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hit;

  assign hit = ((bus.cut_f ^ target_q) & care_q) == '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    count_d   = count_q;
    mc_d      = mc_q;
    target_d  = target_q;
    care_d    = care_q;
    m_x_d     = m_x_q;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        target_d = bus.target;
        care_d   = bus.care;
        idx_d    = '0;
        count_d  = '0;
        mc_d     = '0;
        wait_d   = '0;
        busy_d   = 1'b1;
        state_d  = APPLY;
      end
      APPLY: begin
        if (wait_q == WAIT_LAST) state_d = CHECK;
        else                     wait_d  = wait_q + 1'b1;
      end
      CHECK: begin
        wait_d = '0;
        if (hit) begin
          m_x_d     = idx_q;
          m_valid_d = 1'b1;
          count_d   = count_q + 1'b1;
          state_d   = EMIT;
        end else if (idx_q == LAST) begin
          done_d  = 1'b1;
          mc_d    = count_q;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      EMIT: if (m_valid_q && bus.m_ready) begin
        m_valid_d = 1'b0;
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          mc_d    = count_q;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done is registered on the edge entering FIN so it coincides with the FIN state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      mc_q      <= '0;
      target_q  <= '0;
      care_q    <= '0;
      m_x_q     <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      mc_q      <= mc_d;
      target_q  <= target_d;
      care_q    <= care_d;
      m_x_q     <= m_x_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.cut_x       = idx_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_x         = m_x_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = mc_q;
endmodule

// File: tb/tb_preimage_search.sv
// Bench for preimage_search: table of target/care vectors plus random ones, checked against
// a reference that evaluates the CUT table directly; hand sequences cover stall and reset.
module tb_preimage_search;
  localparam int N_IN = 2, N_OUT = 8, SETTLE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  preimage_search_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus();

  preimage_search #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] cut_tab [4] = '{8'hCE, 8'h7B, 8'h64, 8'h1A};
  assign bus.cut_f = cut_tab[bus.cut_x];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: which candidates satisfy the masked compare.
  function automatic logic [3:0] model_mask(input logic [7:0] t, input logic [7:0] c);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = (((cut_tab[i] ^ t) & c) == 8'h00);
    return m;
  endfunction

  typedef struct {
    logic [7:0] target;
    logic [7:0] care;
    int         stall;
    bit         poke;
    logic [3:0] exp_mask;
    int         exp_cnt;
  } vec_t;

  task automatic run(input vec_t v);
    int q[$];
    int cyc, sl, k, n_exp;
    bit inb, got_done, poked;
    int hx;
    sl = 0; inb = 0; got_done = 0; poked = 0; hx = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.target = v.target; bus.care = v.care;
    bus.m_ready = (v.stall == 0);
    @(negedge clk);
    bus.start = 1'b0; bus.target = ~v.target; bus.care = ~v.care;
    cyc = 1;
    chk("busy_after_start", bus.busy, 1);
    while (!got_done && cyc < 300) begin
      if (bus.done) got_done = 1;
      else begin
        if (bus.m_valid) begin
          if (inb) chk("stall_stable_x", bus.m_x, hx);
          else begin inb = 1; hx = bus.m_x; sl = v.stall; end
          if (sl == 0) begin
            bus.m_ready = 1'b1; q.push_back(bus.m_x); inb = 0;
          end else begin
            bus.m_ready = 1'b0; sl--;
            if (v.poke && !poked) begin
              bus.start = 1'b1; bus.target = 8'h00; bus.care = 8'hFF; poked = 1;
            end
          end
        end else bus.m_ready = (v.stall == 0);
        @(negedge clk);
        bus.start = 1'b0;
        cyc++;
      end
    end
    n_exp = $countones(v.exp_mask);
    chk("done_seen", got_done, 1);
    chk("match_count", bus.match_count, v.exp_cnt);
    chk("latency", cyc, 4 * (SETTLE + 1) + 1 + n_exp * (1 + v.stall));
    chk("beat_count", q.size(), n_exp);
    k = 0;
    for (int i = 0; i < 4; i++) if (v.exp_mask[i]) begin
      if (k < q.size()) chk("beat_x", q[k], i);
      k++;
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("count_held", bus.match_count, v.exp_cnt);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int hi, cyc;
    bus.start = 1'b0; bus.target = '0; bus.care = '0; bus.m_ready = 1'b1;

    // T1..T5 with hand-derived expectations
    vecs.push_back('{8'h7B, 8'hFF, 0, 1'b0, 4'b0010, 1});
    vecs.push_back('{8'h10, 8'h10, 0, 1'b0, 4'b1010, 2});
    vecs.push_back('{8'h00, 8'h00, 0, 1'b0, 4'b1111, 4});
    vecs.push_back('{8'h00, 8'hFF, 0, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'h00, 8'h00, 3, 1'b1, 4'b1111, 4});
    for (int r = 0; r < 8; r++) begin
      hi = $urandom_range(0, 3);
      v.care = 8'($urandom & $urandom);
      v.target = (r % 3 == 2) ? 8'($urandom) : (cut_tab[hi] ^ (8'($urandom) & ~v.care));
      v.stall = $urandom_range(0, 2);
      v.poke = 1'($urandom);
      v.exp_mask = model_mask(v.target, v.care);
      v.exp_cnt = $countones(v.exp_mask);
      vecs.push_back(v);
    end

    repeat (2) @(negedge clk);
    chk("rst_cut_x", bus.cut_x, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_x", bus.m_x, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_match_count", bus.match_count, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    // T6: reset while a match is stalled in EMIT
    @(negedge clk);
    bus.start = 1'b1; bus.target = 8'h00; bus.care = 8'h00; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.m_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("t6_reached_emit", bus.m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_valid", bus.m_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_cut_x", bus.cut_x, 0);
    chk("t6_m_x", bus.m_x, 0);
    chk("t6_match_count", bus.match_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_no_done", bus.done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    run('{8'h7B, 8'hFF, 0, 1'b0, 4'b0010, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
